// File: rtl/clkdiv_ctrl.sv
// Slow-clock divider controller: holds the divide ratio, sequences
// IDLE/RUN/PAUSE/STEP, and produces a 1-cycle tick plus a 50%-duty clock.
// New divisors arrive over a valid/ready port and take effect only at a
// period boundary, so an output period is never truncated or stretched.
module clkdiv_ctrl #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 10000000,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_start,
  input  logic             i_cmd_pause,
  input  logic             i_cmd_stop,
  input  logic             i_cmd_step,
  input  logic             i_cfg_valid,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_tick,
  output logic             o_clk_out,
  output logic [CNT_W-1:0] o_div_cur,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StStep  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div_cur;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_pend_valid;
  logic             r_cfg_err;
  logic             r_tick;
  logic             r_clk_out;

  logic             w_cfg_fire;
  logic             w_cfg_low;
  logic [CNT_W-1:0] w_cfg_clamped;
  logic             w_wrap;

  // Handshake, clamping and end-of-period detection.
  always_comb begin
    w_cfg_fire    = i_cfg_valid & ~r_pend_valid;
    w_cfg_low     = i_cfg_div < MinDiv;
    w_cfg_clamped = w_cfg_low ? MinDiv : i_cfg_div;
    w_wrap        = (r_count == (r_div_cur - One));
  end

  // Controller FSM; all outputs registered, stop has top priority.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_count      <= '0;
      r_div_cur    <= DefDiv;
      r_pend_div   <= '0;
      r_pend_valid <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_tick       <= 1'b0;
      r_clk_out    <= 1'b0;
    end else begin
      r_tick    <= 1'b0;
      r_cfg_err <= 1'b0;
      // Accept only into an empty pending slot, so accept and apply never collide.
      if (w_cfg_fire) begin
        r_pend_valid <= 1'b1;
        r_pend_div   <= w_cfg_clamped;
        r_cfg_err    <= w_cfg_low;
      end
      if (i_cmd_stop) begin
        r_state   <= StIdle;
        r_count   <= '0;
        r_clk_out <= 1'b0;
        if (r_pend_valid) begin
          r_div_cur    <= r_pend_div;
          r_pend_valid <= 1'b0;
        end
      end else begin
        case (r_state)
          StIdle: begin
            r_count   <= '0;
            r_clk_out <= 1'b0;
            if (r_pend_valid) begin
              r_div_cur    <= r_pend_div;
              r_pend_valid <= 1'b0;
            end
            if (i_cmd_start) r_state <= StRun;
          end
          StPause: begin
            // A divisor applied while paused restarts the period from zero.
            if (r_pend_valid) begin
              r_div_cur    <= r_pend_div;
              r_pend_valid <= 1'b0;
              r_count      <= '0;
            end
            if (i_cmd_start)     r_state <= StRun;
            else if (i_cmd_step) r_state <= StStep;
          end
          StRun, StStep: begin
            if (i_cmd_pause) begin
              r_state <= StPause;
            end else if (w_wrap) begin
              r_count   <= '0;
              r_tick    <= 1'b1;
              r_clk_out <= ~r_clk_out;
              if (r_pend_valid) begin
                r_div_cur    <= r_pend_div;
                r_pend_valid <= 1'b0;
              end
              if (r_state == StStep) r_state <= StPause;
            end else begin
              r_count <= r_count + One;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Output mapping; ready is simply "no divisor waiting to be applied".
  always_comb begin
    o_cfg_ready = ~r_pend_valid;
    o_cfg_err   = r_cfg_err;
    o_tick      = r_tick;
    o_clk_out   = r_clk_out;
    o_div_cur   = r_div_cur;
    o_state     = r_state;
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl with DEFAULT_DIV = 4.
module tb_clkdiv_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_start, cmd_pause, cmd_stop, cmd_step;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready, cfg_err, tick, clk_out;
  logic [CNT_W-1:0] div_cur;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  clkdiv_ctrl #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(4),
    .MIN_DIV    (2)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cmd_start(cmd_start),
    .i_cmd_pause(cmd_pause),
    .i_cmd_stop (cmd_stop),
    .i_cmd_step (cmd_step),
    .i_cfg_valid(cfg_valid),
    .i_cfg_div  (cfg_div),
    .o_cfg_ready(cfg_ready),
    .o_cfg_err  (cfg_err),
    .o_tick     (tick),
    .o_clk_out  (clk_out),
    .o_div_cur  (div_cur),
    .o_state    (state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_start = 0; cmd_pause = 0; cmd_stop = 0; cmd_step = 0;
    cfg_valid = 0; cfg_div = '0;
    cyc(2);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state); end
    checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL reset_div got=%0d exp=4", div_cur); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    checks++; if ({cfg_err, tick, clk_out} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got=%b exp=000", {cfg_err, tick, clk_out});
    end
    reset = 1'b0;
    cyc(1);
  endtask

  // Start, then ticks at edges 4 and 8 after the start edge.
  task automatic test_run();
    cmd_start = 1; cyc(1); cmd_start = 0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_state got=%b exp=01", state); end
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      checks++;
      if (tick !== (i % 4 == 0)) begin errors++; $display("FAIL run_tick i=%0d got=%b", i, tick); end
      checks++;
      if (clk_out !== (i >= 4 && i < 8)) begin
        errors++; $display("FAIL run_clkout i=%0d got=%b", i, clk_out);
      end
    end
  endtask

  // Offered right after a tick: current period stays 4, the next is 6.
  task automatic test_cfg_boundary();
    cfg_valid = 1; cfg_div = 8'd6; cyc(1); cfg_valid = 0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_drop got=%b exp=0", cfg_ready); end
    for (int i = 2; i <= 10; i++) begin
      cyc(1);
      checks++;
      if (tick !== (i == 4 || i == 10)) begin errors++; $display("FAIL cfg_tick i=%0d got=%b", i, tick); end
      checks++;
      if (cfg_ready !== (i >= 4)) begin errors++; $display("FAIL cfg_ready i=%0d got=%b", i, cfg_ready); end
      checks++;
      if (div_cur !== ((i >= 4) ? 8'd6 : 8'd4)) begin
        errors++; $display("FAIL cfg_div i=%0d got=%0d", i, div_cur);
      end
    end
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL cfg_clkout got=%b exp=0", clk_out); end
  endtask

  // cfg_div=1 is clamped to 2, flagged, and applied at the next wrap.
  task automatic test_clamp();
    cfg_valid = 1; cfg_div = 8'd1; cyc(1); cfg_valid = 0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL clamp_err got=%b exp=1", cfg_err); end
    for (int i = 2; i <= 10; i++) begin
      cyc(1);
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL clamp_err_pulse i=%0d got=%b", i, cfg_err); end
      checks++;
      if (tick !== (i == 6 || i == 8 || i == 10)) begin
        errors++; $display("FAIL clamp_tick i=%0d got=%b", i, tick);
      end
    end
    checks++; if (div_cur !== 8'd2) begin errors++; $display("FAIL clamp_div got=%0d exp=2", div_cur); end
  endtask

  // Back to div 4 from IDLE, pause at count 2, resume -> tick 2 edges later.
  task automatic test_pause();
    cmd_stop = 1; cyc(1); cmd_stop = 0;
    checks++; if ({state, clk_out} !== 3'b000) begin
      errors++; $display("FAIL stop_idle got=%b exp=000", {state, clk_out});
    end
    cfg_valid = 1; cfg_div = 8'd4; cyc(1); cfg_valid = 0;
    cyc(1);
    checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL idle_apply got=%0d exp=4", div_cur); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", cfg_ready); end
    cmd_start = 1; cyc(1); cmd_start = 0;
    cyc(2);
    cmd_pause = 1; cyc(1); cmd_pause = 0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_state got=%b exp=10", state); end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      checks++;
      if ({tick, clk_out, state} !== 4'b0010) begin
        errors++; $display("FAIL pause_hold i=%0d got=%b exp=0010", i, {tick, clk_out, state});
      end
    end
    cmd_start = 1; cyc(1); cmd_start = 0;
    cyc(1);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL resume_early got=%b exp=0", tick); end
    cyc(1);
    checks++; if ({tick, clk_out} !== 2'b11) begin
      errors++; $display("FAIL resume_tick got=%b exp=11", {tick, clk_out});
    end
  endtask

  // Single steps from PAUSE, then step+stop together goes to IDLE.
  task automatic test_step();
    cmd_pause = 1; cyc(1); cmd_pause = 0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL step_pause got=%b exp=10", state); end
    for (int n = 0; n < 2; n++) begin
      cmd_step = 1; cyc(1); cmd_step = 0;
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL step_state n=%0d got=%b", n, state); end
      for (int i = 1; i <= 6; i++) begin
        cyc(1);
        checks++;
        if (tick !== (i == 4)) begin errors++; $display("FAIL step_tick n=%0d i=%0d got=%b", n, i, tick); end
        checks++;
        if (state !== ((i >= 4) ? 2'b10 : 2'b11)) begin
          errors++; $display("FAIL step_fsm n=%0d i=%0d got=%b", n, i, state);
        end
      end
      checks++;
      if (clk_out !== (n == 1)) begin errors++; $display("FAIL step_clkout n=%0d got=%b", n, clk_out); end
    end
    cmd_step = 1; cmd_stop = 1; cyc(1); cmd_step = 0; cmd_stop = 0;
    checks++; if ({state, clk_out, tick} !== 4'b0000) begin
      errors++; $display("FAIL step_stop got=%b exp=0000", {state, clk_out, tick});
    end
  endtask

  // Asynchronous reset with a divisor pending discards it.
  task automatic test_reset_mid();
    cmd_start = 1; cyc(1); cmd_start = 0;
    cyc(4);
    checks++; if ({tick, clk_out} !== 2'b11) begin
      errors++; $display("FAIL mid_pre_tick got=%b exp=11", {tick, clk_out});
    end
    cfg_valid = 1; cfg_div = 8'd9; cyc(1); cfg_valid = 0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pending got=%b exp=0", cfg_ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({state, cfg_ready, cfg_err, tick, clk_out} !== 6'b001000) begin
      errors++; $display("FAIL mid_async got=%b exp=001000", {state, cfg_ready, cfg_err, tick, clk_out});
    end
    checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL mid_div got=%0d exp=4", div_cur); end
    cyc(2);
    reset = 1'b0;
    cyc(2);
    checks++; if (div_cur !== 8'd4) begin errors++; $display("FAIL mid_release_div got=%0d exp=4", div_cur); end
    cmd_start = 1; cyc(1); cmd_start = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      checks++;
      if (tick !== (i == 4)) begin errors++; $display("FAIL mid_restart i=%0d got=%b", i, tick); end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_cfg_boundary();
    test_clamp();
    test_pause();
    test_step();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
